// File: rtl/logic_resp_checker.sv
// Streaming checker for the 64-bit XOR/OR/AND logic unit: two-stage compare pipeline with run statistics.
// Optional MISR signature over the accepted results is enabled with LOGIC_CHK_MISR_EN.
module logic_resp_checker #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_xor,
    input  logic [WIDTH-1:0] in_or,
    input  logic [WIDTH-1:0] in_and,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [2:0]       first_err_mask
`ifdef LOGIC_CHK_MISR_EN
    ,
    output logic [WIDTH-1:0] signature
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [2:0]       fmask_q, fmask_d;

    // Stage-1 capture of the accepted vector
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] x_q, x_d, o_q, o_d, n_q, n_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    logic       accept;
    logic       clear;
    logic [2:0] mask;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid & in_ready;
    assign clear    = start & ((state_q == IDLE) | (state_q == DONE));
    assign mask     = {x_q != (a_q ^ b_q), o_q != (a_q | b_q), n_q != (a_q & b_q)};

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fidx_d   = fidx_q;
        fmask_d  = fmask_q;
        s1_vld_d = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        o_d      = o_q;
        n_d      = n_q;
        idx_d    = idx_q;

        if (s1_vld_q && (mask != 3'b000)) begin
            // err_q==0 means no earlier failure in this run, so this is the first one
            if (err_q == '0) begin
                fidx_d  = idx_q;
                fmask_d = mask;
            end
            if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (clear) begin
                    state_d = RUN;
                    vec_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fmask_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    s1_vld_d = 1'b1;
                    a_d      = in_a;
                    b_d      = in_b;
                    x_d      = in_xor;
                    o_d      = in_or;
                    n_d      = in_and;
                    idx_d    = vec_q;
                    if (vec_q != CNT_MAX) vec_d = vec_q + 1'b1;
                    if (in_last) state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            err_q    <= '0;
            fidx_q   <= '0;
            fmask_q  <= '0;
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            o_q      <= '0;
            n_q      <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
            fmask_q  <= fmask_d;
            s1_vld_q <= s1_vld_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            o_q      <= o_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
        end
    end

    assign busy           = (state_q == RUN) | (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign pass           = done & (err_q == '0);
    assign vec_count      = vec_q;
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_mask = fmask_q;

`ifdef LOGIC_CHK_MISR_EN
    // x^64+x^4+x^3+x+1: feedback taps land on bits 4,3,1,0
    localparam logic [WIDTH-1:0] POLY = WIDTH'('h1B);

    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] or_rot, and_rot;

    assign or_rot  = {in_or[WIDTH/2-1:0], in_or[WIDTH-1:WIDTH/2]};
    assign and_rot = {in_and[WIDTH/4-1:0], in_and[WIDTH-1:WIDTH/4]};

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '1;
        end else if (accept) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0)
                    ^ in_xor ^ or_rot ^ and_rot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sig_q <= '1;
        else     sig_q <= sig_d;
    end

    assign signature = sig_q;
`endif

endmodule

// File: tb/tb_logic_resp_checker.sv
// Directed bench for logic_resp_checker: run-level behavioural model compared every cycle, plus literal checks.
// Signature checks are compiled in when LOGIC_CHK_MISR_EN is defined.
module tb_logic_resp_checker;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic        in_ready, busy, done, pass;
    logic [63:0] in_a, in_b, in_xor, in_or, in_and;
    logic [15:0] vec_count, err_count, first_err_idx;
    logic [2:0]  first_err_mask;
`ifdef LOGIC_CHK_MISR_EN
    logic [63:0] signature;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    logic_resp_checker #(.WIDTH(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_xor(in_xor), .in_or(in_or), .in_and(in_and),
        .in_last(in_last), .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_mask(first_err_mask)
`ifdef LOGIC_CHK_MISR_EN
        , .signature(signature)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Run-level model: m_st 0=idle 1=run 2=drain 3=done; a vector's verdict shows up one edge after it is accepted.
    int          m_st, m_vec, m_err, m_fidx, pend_idx;
    bit [2:0]    m_fmask, pend_mask;
    bit          pend;
    logic [63:0] m_sig;

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_vec = 0; m_err = 0; m_fidx = 0; m_fmask = 0; pend = 0; m_sig = '1;
        end else begin
            if (pend) begin
                if (pend_mask != 0) begin
                    if (m_err == 0) begin m_fidx = pend_idx; m_fmask = pend_mask; end
                    if (m_err < 65535) m_err++;
                end
                pend = 0;
            end
            case (m_st)
                0, 3: if (start) begin
                    m_st = 1; m_vec = 0; m_err = 0; m_fidx = 0; m_fmask = 0; m_sig = '1;
                end
                1: if (in_valid) begin
                    pend_mask = {in_xor !== (in_a ^ in_b), in_or !== (in_a | in_b), in_and !== (in_a & in_b)};
                    pend      = 1;
                    pend_idx  = m_vec;
                    if (m_vec < 65535) m_vec++;
                    m_sig = (m_sig << 1) ^ (m_sig[63] ? 64'h1B : 64'h0) ^ in_xor
                            ^ ((in_or >> 32) | (in_or << 32)) ^ ((in_and >> 16) | (in_and << 48));
                    if (in_last) m_st = 2;
                end
                2: m_st = 3;
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_st == 1));
            chk("busy", 64'(busy), 64'(m_st == 1 || m_st == 2));
            chk("done", 64'(done), 64'(m_st == 3));
            chk("pass", 64'(pass), 64'(m_st == 3 && m_err == 0));
            chk("vec_count", 64'(vec_count), 64'(m_vec));
            chk("err_count", 64'(err_count), 64'(m_err));
            chk("first_err_idx", 64'(first_err_idx), 64'(m_fidx));
            chk("first_err_mask", 64'(first_err_mask), 64'(m_fmask));
`ifdef LOGIC_CHK_MISR_EN
            chk("signature", signature, m_sig);
`endif
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_run();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send(input logic [63:0] a, b, x, o, n, input bit last);
        in_valid = 1'b1; in_a = a; in_b = b; in_xor = x; in_or = o; in_and = n; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; in_xor = '1; in_or = '1; in_and = '1;
    endtask

    // Walking-one stream; bad_* pick the corrupted vector (-1 for none).
    task automatic stream(input logic [63:0] b, input int nv, input bit gaps,
                          input int bad_and, input int bad_xor, input int all_bad);
        logic [63:0] a, x, o, n;
        for (int i = 0; i < nv; i++) begin
            a = 64'd1 << i;
            x = a ^ b; o = a | b; n = a & b;
            if (i == bad_and) n[0] = ~n[0];
            if (i == bad_xor) x = x ^ 64'hF0;
            if (i == all_bad) begin x = ~x; o = ~o; n = ~n; end
            send(a, b, x, o, n, i == nv - 1);
            if (gaps && i != nv - 1) begin
                if (i == 10) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic finish_run(input string tag, input int exp_vec, input int exp_err,
                              input int exp_idx, input int exp_mask, input bit exp_pass);
        chk({tag, "_done_after_last"}, 64'(done), 64'd0);
        chk({tag, "_ready_after_last"}, 64'(in_ready), 64'd0);
        tick();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_vec"}, 64'(vec_count), 64'(exp_vec));
        chk({tag, "_err"}, 64'(err_count), 64'(exp_err));
        chk({tag, "_fidx"}, 64'(first_err_idx), 64'(exp_idx));
        chk({tag, "_fmask"}, 64'(first_err_mask), 64'(exp_mask));
        chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
        tick(); tick();
        chk({tag, "_done_held"}, 64'(done), 64'd1);
    endtask

`ifdef LOGIC_CHK_MISR_EN
    logic [63:0] sig_a, sig_b, sig_c;
`endif

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; in_xor = '0; in_or = '0; in_and = '0;
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_vec", 64'(vec_count), 64'd0);
`ifdef LOGIC_CHK_MISR_EN
        chk("rst_sig", signature, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        start_run();
        chk("run_busy", 64'(busy), 64'd1);
        stream(64'h0, 64, 1'b0, -1, -1, -1);
        finish_run("walk_b0", 64, 0, 0, 0, 1'b1);
`ifdef LOGIC_CHK_MISR_EN
        sig_a = signature;
`endif

        start_run();
        stream('1, 64, 1'b1, -1, -1, -1);
        finish_run("walk_gaps", 64, 0, 0, 0, 1'b1);

        start_run();
        chk("restart_clear_vec", 64'(vec_count), 64'd0);
        stream('1, 64, 1'b0, 5, 9, -1);
        finish_run("two_err", 64, 2, 5, 3'b001, 1'b0);

        start_run();
        chk("restart_clear_err", 64'(err_count), 64'd0);
        stream(64'h0, 4, 1'b0, -1, -1, 0);
        finish_run("all_bad0", 4, 1, 0, 3'b111, 1'b0);

        start_run();
        for (int i = 0; i < 30; i++) send(64'd1 << i, 64'h0, 64'd1 << i, 64'd1 << i, 64'h0, 1'b0);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_vec", 64'(vec_count), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        start_run();
        stream(64'h0, 64, 1'b0, -1, -1, -1);
        finish_run("after_rst", 64, 0, 0, 0, 1'b1);

`ifdef LOGIC_CHK_MISR_EN
        sig_b = signature;
        chk("sig_replay_same", sig_b, sig_a);
        start_run();
        stream(64'h0, 64, 1'b0, 20, -1, -1);
        finish_run("sig_flip", 64, 1, 20, 3'b001, 1'b0);
        sig_c = signature;
        chk("sig_flip_differs", 64'(sig_c != sig_a), 64'd1);
`endif

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
